// File: rtl/packed_simd_accumulator.sv
// Multi-beat packed SIMD accumulator: 1, 2 or 4 isolated signed lanes,
// each wrapping or saturating independently with its own sticky overflow flag.

module packed_simd_accumulator_lane #(
    parameter int LW       = 8,
    parameter int PW       = 6,
    parameter int SATURATE = 0
) (
    input  logic [LW-1:0] acc_i,
    input  logic [LW-1:0] data_i,
    output logic [LW-1:0] sum_o,
    output logic          ovf_o
);

    logic [LW-1:0] shifted;
    logic [LW-1:0] opnd;
    logic [LW-1:0] raw;

    always_comb begin
        // Left-justify the payload, then arithmetic-shift back to sign-extend it.
        shifted = data_i << (LW - PW);
        opnd    = $signed(shifted) >>> (LW - PW);
        raw     = acc_i + opnd;
        ovf_o   = (acc_i[LW-1] == opnd[LW-1]) && (raw[LW-1] != acc_i[LW-1]);
        sum_o   = raw;
        if ((SATURATE != 0) && ovf_o) begin
            sum_o = acc_i[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
        end
    end

endmodule

module packed_simd_accumulator #(
    parameter int WIDTH    = 32,
    parameter int P2_W     = 10,
    parameter int P4_W     = 6,
    parameter int LEN_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic [3:0]       ovf_o,
    output logic             busy_o
);

    localparam int W2 = WIDTH / 2;
    localparam int W4 = WIDTH / 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic [3:0]         ovf_q, ovf_d;
    logic [LEN_W-1:0]   cnt_inc;

    // All three lane geometries are computed in parallel; the latched mode picks one.
    logic [WIDTH-1:0]       sum1;
    logic                   ovf1;
    logic [1:0][W2-1:0]     sum2;
    logic [1:0]             ovf2;
    logic [3:0][W4-1:0]     sum4;
    logic [3:0]             ovf4;
    logic [WIDTH-1:0]       lane_sum;
    logic [3:0]             lane_ovf;

    packed_simd_accumulator_lane #(
        .LW(WIDTH), .PW(WIDTH), .SATURATE(SATURATE)
    ) u_lane1 (
        .acc_i (acc_q),
        .data_i(in_data_i),
        .sum_o (sum1),
        .ovf_o (ovf1)
    );

    for (genvar k = 0; k < 2; k++) begin : g_lane2
        packed_simd_accumulator_lane #(
            .LW(W2), .PW(P2_W), .SATURATE(SATURATE)
        ) u_lane (
            .acc_i (acc_q[k*W2 +: W2]),
            .data_i(in_data_i[k*W2 +: W2]),
            .sum_o (sum2[k]),
            .ovf_o (ovf2[k])
        );
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane4
        packed_simd_accumulator_lane #(
            .LW(W4), .PW(P4_W), .SATURATE(SATURATE)
        ) u_lane (
            .acc_i (acc_q[k*W4 +: W4]),
            .data_i(in_data_i[k*W4 +: W4]),
            .sum_o (sum4[k]),
            .ovf_o (ovf4[k])
        );
    end

    // Mode 11 is reserved and decodes as the single-lane geometry.
    always_comb begin
        case (mode_q)
            2'b01: begin
                lane_sum = sum2;
                lane_ovf = {2'b00, ovf2};
            end
            2'b10: begin
                lane_sum = sum4;
                lane_ovf = ovf4;
            end
            default: begin
                lane_sum = sum1;
                lane_ovf = {3'b000, ovf1};
            end
        endcase
    end

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    len_d   = len_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = '0;
                    state_d = (len_i != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (in_valid_i) begin
                    acc_d = lane_sum;
                    ovf_d = ovf_q | lane_ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == ST_ACCUM);
    assign res_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign res_data_o  = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_packed_simd_accumulator.sv
// Bench for packed_simd_accumulator: wrap and saturating instances side by side,
// fixed vectors with hand-derived results plus random jobs against a lane-arithmetic model.

module tb_packed_simd_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [7:0]  len_i = 8'd0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i = 32'd0;
    logic        res_ready_i = 1'b0;

    logic        in_ready_o, res_valid_o, busy_o;
    logic [31:0] res_data_o;
    logic [3:0]  ovf_o;
    logic        in_ready_s, res_valid_s, busy_s;
    logic [31:0] res_data_s;
    logic [3:0]  ovf_s;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    packed_simd_accumulator #(.WIDTH(32), .P2_W(10), .P4_W(6), .LEN_W(8), .SATURATE(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .ovf_o(ovf_o), .busy_o(busy_o)
    );

    packed_simd_accumulator #(.WIDTH(32), .P2_W(10), .P4_W(6), .LEN_W(8), .SATURATE(1)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_s), .in_data_i(in_data_i),
        .res_valid_o(res_valid_s), .res_ready_i(res_ready_i), .res_data_o(res_data_s),
        .ovf_o(ovf_s), .busy_o(busy_s)
    );

    typedef struct {
        logic [1:0]  mode;
        int          len;
        logic [31:0] beats [6];
        logic [31:0] exp_w;
        logic [3:0]  ovf_w;
        logic [31:0] exp_s;
        logic [3:0]  ovf_s;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [1:0] m, input int n,
                           input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] bn,
                           input logic [31:0] ew, input logic [3:0] ow,
                           input logic [31:0] es, input logic [3:0] os);
        tbl[i].mode = m;
        tbl[i].len  = n;
        tbl[i].beats[0] = b0;
        tbl[i].beats[1] = b1;
        for (int j = 2; j < 6; j++) tbl[i].beats[j] = (j == n - 1) ? bn : b1;
        tbl[i].exp_w = ew;
        tbl[i].ovf_w = ow;
        tbl[i].exp_s = es;
        tbl[i].ovf_s = os;
    endtask

    // Reference: each lane is an ideal signed integer, range-checked after every beat.
    function automatic void model(input logic [1:0] m, input logic [31:0] beats[$], input bit sat,
                                  output logic [31:0] res, output logic [3:0] ovf);
        int nl, lw, pw;
        longint acc, u, v, mx, mn;
        nl = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        lw = 32 / nl;
        pw = (nl == 1) ? 32 : (nl == 2) ? 10 : 6;
        res = 32'd0;
        ovf = 4'd0;
        for (int k = 0; k < nl; k++) begin
            acc = 0;
            mx  = (longint'(1) << (lw - 1)) - 1;
            mn  = -(longint'(1) << (lw - 1));
            for (int b = 0; b < beats.size(); b++) begin
                u = (longint'(beats[b]) >> (k * lw)) & ((longint'(1) << pw) - 1);
                v = (u >= (longint'(1) << (pw - 1))) ? u - (longint'(1) << pw) : u;
                acc = acc + v;
                if (acc > mx || acc < mn) begin
                    ovf[k] = 1'b1;
                    if (sat) acc = (acc > mx) ? mx : mn;
                    else     acc = (acc > mx) ? acc - (longint'(1) << lw) : acc + (longint'(1) << lw);
                end
            end
            res = res | 32'((acc & ((longint'(1) << lw) - 1)) << (k * lw));
        end
    endfunction

    task automatic run_job(input logic [1:0] m, input logic [31:0] beats[$], input int gap,
                           input int hold, output logic [31:0] r0, output logic [31:0] r1,
                           output logic [3:0] o0, output logic [3:0] o1);
        int idx, cyc, n;
        n = beats.size();
        start_i = 1'b1;
        mode_i  = m;
        len_i   = 8'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        mode_i  = 2'($urandom);
        len_i   = 8'($urandom);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            chk("in_ready_accum", 32'(in_ready_o), 32'd1);
            chk("res_valid_early", 32'(res_valid_o), 32'd0);
            in_valid_i = ($urandom_range(99) >= gap);
            in_data_i  = in_valid_i ? beats[idx] : $urandom;
            if (in_valid_i && in_ready_o) idx++;
            @(posedge clk_i); #1;
            cyc++;
        end
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        chk("beats_accepted", 32'(idx), 32'(n));
        chk("res_valid_one_cycle", 32'(res_valid_o), 32'd1);
        chk("in_ready_done", 32'(in_ready_o), 32'd0);
        r0 = res_data_o;
        r1 = res_data_s;
        o0 = ovf_o;
        o1 = ovf_s;
        for (int h = 0; h < hold; h++) begin
            start_i = (h == 3);
            mode_i  = 2'b00;
            len_i   = 8'd1;
            @(posedge clk_i); #1;
            chk("hold_data", res_data_o, r0);
            chk("hold_data_sat", res_data_s, r1);
            chk("hold_valid_busy", {30'd0, res_valid_o, busy_o}, 32'd3);
        end
        start_i = 1'b0;
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        chk("idle_after_handshake", {30'd0, busy_o, res_valid_o}, 32'd0);
        chk("ovf_held_idle", 32'(ovf_o), 32'(o0));
        if (hold > 0) begin
            @(posedge clk_i); #1;
            chk("start_ignored", {30'd0, busy_o, in_ready_o}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] r0, r1, e0, e1, g0, g1;
        logic [3:0]  o0, o1, eo0, eo1, go0, go1;
        logic [1:0]  m;
        int n;

        set_vec(0, 2'b01, 3, 32'h000103FF, 32'h000103FF, 32'h000103FF, 32'h0003FFFD, 4'h0, 32'h0003FFFD, 4'h0);
        set_vec(1, 2'b10, 5, 32'h1F1F1F1F, 32'h1F1F1F1F, 32'h1F1F1F1F, 32'h9B9B9B9B, 4'hF, 32'h7F7F7F7F, 4'hF);
        set_vec(2, 2'b00, 2, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 32'h80000000, 4'h1, 32'h7FFFFFFF, 4'h1);
        set_vec(3, 2'b11, 2, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 32'h80000000, 4'h1, 32'h7FFFFFFF, 4'h1);
        set_vec(4, 2'b00, 0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h00000000, 4'h0, 32'h00000000, 4'h0);
        set_vec(5, 2'b10, 2, 32'hE0A06020, 32'hE0A06020, 32'hE0A06020, 32'hC0C0C0C0, 4'h0, 32'hC0C0C0C0, 4'h0);
        set_vec(6, 2'b01, 2, 32'hFC000200, 32'hFC000200, 32'hFC000200, 32'h0000FC00, 4'h0, 32'h0000FC00, 4'h0);
        set_vec(7, 2'b10, 5, 32'h20202020, 32'h20202020, 32'h20202020, 32'h60606060, 4'hF, 32'h80808080, 4'hF);
        set_vec(8, 2'b10, 6, 32'h1F1F1F1F, 32'h1F1F1F1F, 32'h21212121, 32'h7C7C7C7C, 4'hF, 32'h60606060, 4'hF);

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outputs", {res_data_o ^ res_data_s, 4'd0}, 36'd0);
        chk("reset_ctrl", {23'd0, ovf_o, ovf_s, in_ready_o, res_valid_o, busy_o}, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            q.delete();
            for (int j = 0; j < tbl[i].len; j++) q.push_back(tbl[i].beats[j]);
            run_job(tbl[i].mode, q, 0, 0, r0, r1, o0, o1);
            chk($sformatf("vec%0d_wrap", i), r0, tbl[i].exp_w);
            chk($sformatf("vec%0d_wrap_ovf", i), 32'(o0), 32'(tbl[i].ovf_w));
            chk($sformatf("vec%0d_sat", i), r1, tbl[i].exp_s);
            chk($sformatf("vec%0d_sat_ovf", i), 32'(o1), 32'(tbl[i].ovf_s));
        end

        // Result held under backpressure while a stray start is pulsed.
        q.delete();
        repeat (3) q.push_back($urandom);
        model(2'b10, q, 1'b0, e0, eo0);
        model(2'b10, q, 1'b1, e1, eo1);
        run_job(2'b10, q, 0, 10, r0, r1, o0, o1);
        chk("hold_result", r0, e0);
        chk("hold_result_sat", r1, e1);

        // Random jobs, each run gapless and again with input gaps.
        for (int t = 0; t < 16; t++) begin
            m = 2'($urandom);
            n = $urandom_range(12);
            q.delete();
            for (int j = 0; j < n; j++) q.push_back($urandom);
            model(m, q, 1'b0, e0, eo0);
            model(m, q, 1'b1, e1, eo1);
            run_job(m, q, 0, 0, g0, g1, go0, go1);
            run_job(m, q, 40, 0, r0, r1, o0, o1);
            chk($sformatf("rnd%0d_wrap", t), g0, e0);
            chk($sformatf("rnd%0d_sat", t), g1, e1);
            chk($sformatf("rnd%0d_ovf", t), {24'd0, go0, go1}, {24'd0, eo0, eo1});
            chk($sformatf("rnd%0d_gap_wrap", t), r0, e0);
            chk($sformatf("rnd%0d_gap_sat", t), r1, e1);
            chk($sformatf("rnd%0d_gap_ovf", t), {24'd0, o0, o1}, {24'd0, eo0, eo1});
        end

        // Reset in the middle of a job, after two of four beats.
        start_i = 1'b1;
        mode_i  = 2'b00;
        len_i   = 8'd4;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 32'h7FFFFFFF;
        repeat (2) @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        chk("mid_busy_before_rst", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_data", res_data_o, 32'd0);
        chk("mid_rst_data_sat", res_data_s, 32'd0);
        chk("mid_rst_ctrl", {23'd0, ovf_o, ovf_s, in_ready_o, res_valid_o, busy_o}, 32'd0);
        q.delete();
        q.push_back(32'h00000005);
        run_job(2'b00, q, 0, 0, r0, r1, o0, o1);
        chk("post_rst_job", r0, 32'h00000005);
        chk("post_rst_job_sat", r1, 32'h00000005);
        chk("post_rst_ovf", {24'd0, o0, o1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packed_simd_accumulator.md
Name: packed_simd_accumulator

Overview:
Parametrised, sequential successor to the packed adder in the Ibex mixed-precision datapath. It accumulates a stream of packed sub-word partial products over a programmable number of beats, in 1, 2 or 4 isolated lanes. Each lane's payload is sign-extended to the lane width. Each lane is independently wrapped or saturated, and each lane has its own sticky overflow flag. The block sits behind the MAC/partial-product unit and hands one packed result word to the register-file writeback or to the next layer buffer.

Parameters:
WIDTH, 32, accumulator/data width in bits; must be divisible by 4.
P2_W, 10, payload width per lane in 2-lane mode; must be ≤ WIDTH/2.
P4_W, 6, payload width per lane in 4-lane mode; must be ≤ WIDTH/4.
LEN_W, 8, width of the beat-count input.
SATURATE, 0, 0 = per-lane wrap modulo 2^LW; 1 = per-lane signed clamp.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  starts a job; sampled only in IDLE
mode_i  input  2  00 = 1 lane, 01 = 2 lanes, 10 = 4 lanes, 11 = reserved (behaves as 00)
len_i  input  LEN_W  number of beats in the job
in_valid_i  input  1  input beat valid
in_ready_o  output  1  block accepts a beat
in_data_i  input  WIDTH  packed lane payloads
res_valid_o  output  1  result valid
res_ready_i  input  1  consumer accepts the result
res_data_o  output  WIDTH  packed lane accumulators
ovf_o  output  4  sticky per-lane overflow flags; bit k = lane k
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) takes priority over everything, including an in-flight job.
  - State goes to IDLE; accumulator, beat counter, latched mode and latched length clear to 0.
  - Every output is 0 on the cycle after rst_i is sampled high.
- Lane geometry (L lanes, LW = WIDTH/L bits each):
  - Lane k occupies bits [k*LW +: LW] of both in_data_i and res_data_o.
  - Payload width PW: WIDTH in 1-lane mode, P2_W in 2-lane mode, P4_W in 4-lane mode.
  - Each lane's low PW bits are sign-extended to LW. Bits above PW within the lane are ignored.
  - No carry or borrow crosses a lane boundary.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready_o=0, res_valid_o=0.
    - start_i=1 latches mode_i and len_i, clears the accumulator, counter and ovf_o.
    - len_i≠0 goes to ACCUM next cycle. len_i=0 goes to DONE next cycle with a result of 0.
  - ACCUM: in_ready_o=1.
    - A beat transfers when in_valid_i & in_ready_o. Each beat adds to every lane and increments the counter.
    - in_valid_i low stalls the job with no change.
    - The beat that makes the counter equal the latched length moves the FSM to DONE. The updated accumulator is registered in the same edge.
    - res_valid_o=1 one cycle after that last beat.
  - DONE: res_valid_o=1; res_data_o and ovf_o are held stable.
    - The result transfers on res_ready_i=1; the FSM returns to IDLE next cycle.
    - While res_ready_i=0, the block holds indefinitely.
- start_i is ignored outside IDLE; mode_i and len_i are only sampled with start.
- Throughput: one beat per cycle. A new start is accepted earliest on the cycle after the result handshake.
- Per-lane arithmetic, signed add of LW bits:
  - Overflow: operand signs equal and sum sign different.
  - Any overflow during a job sets the lane's ovf_o bit, which stays set until the next start or reset.
  - SATURATE=0: the sum wraps.
  - SATURATE=1: the sum clamps to +2^(LW-1)-1 or -2^(LW-1) and stays clamped until the arithmetic brings it back in range.
- ovf_o bits for unused lanes read 0. ovf_o is valid while res_valid_o=1 and holds its value in IDLE until the next start.

Test Plan:
- 2-lane mode, P2_W=10, len=3, in_data=0x000103FF ×3 (lane0 = -1, lane1 = +1) -> res_data_o=0x0003FFFD, ovf_o=0000; res_valid_o rises exactly 1 cycle after the 3rd beat.
- 4-lane mode, P4_W=6, SATURATE=0, len=5, in_data=0x1F1F1F1F -> res_data_o=0x9B9B9B9B, ovf_o=1111. Same stimulus with SATURATE=1 -> 0x7F7F7F7F, ovf_o=1111.
- 1-lane mode, len=2, beats 0x7FFFFFFF then 0x00000001 -> res_data_o=0x80000000, ovf_o=0001. mode_i=11 with the same stimulus gives the identical result.
- start with len=0 -> res_valid_o=1 one cycle later with res_data_o=0, ovf_o=0000, and no beats accepted.
- Backpressure: random in_valid_i gaps give the same sum as the gapless run. Hold res_ready_i low 10 cycles and pulse start_i in that window -> result stable, start ignored, busy_o=1, then IDLE after the handshake.
- Assert rst_i mid-ACCUM after 2 of 4 beats -> all outputs 0 next cycle. A fresh job with len=1, in_data=0x00000005 (1-lane mode) returns exactly 0x00000005.
